// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame geometry, baud divider math and TX FSM encoding.
package uart_tx_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // Clocks per oversample tick; the RX baud generator uses the same formula.
    function automatic int calc_div(input int freq_hz, input int baud);
        return freq_hz / (baud * OVERSAMPLE);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_baudgen.sv
// Oversample tick generator for the transmitter: one-cycle tick every DIV clocks,
// with a synchronous clear that restarts the period.
module baudgen_tx #(
    parameter int DIV = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next divider count: clear wins, otherwise wrap at the end of the period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || cnt_q == LAST)
            cnt_d = '0;
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding register for gap-free frames.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int baudrate = 9600,
    parameter int freq     = 2000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 TX_start,
    input  logic [DATA_BITS-1:0] Data_in,
    output logic                 Serial_out,
    output logic                 TX_ready,
    output logic                 TX_busy,
    output logic                 TX_done
);

    localparam int DIV = calc_div(freq, baudrate);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic                 load;
    logic                 tick;

    // The divider is restarted on every frame load so the start bit is full length.
    baudgen_tx #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .tick  (tick)
    );

    // Frame sequencer: counts 16 ticks per bit, loads from the holding register.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        done_d     = 1'b0;
        load       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) load = 1'b1;
            end
            ST_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        done_d = 1'b1;
                        // A queued byte chains straight into the next start bit.
                        if (hold_valid_q) load = 1'b1;
                        else              state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d    = ST_START;
            shift_d    = hold_q;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
        end
    end

    // Holding register: accept only when empty, empty on load.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (load) begin
            hold_valid_d = 1'b0;
        end else if (TX_start && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_d       = Data_in;
        end
    end

    // Line level follows the state being entered so the output can be registered.
    always_comb begin
        serial_d = 1'b1;
        unique case (state_d)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_d[0];
            default:  serial_d = 1'b1;
        endcase
    end

    // State registers; reset drops the frame and returns the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            serial_q     <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            serial_q     <= serial_d;
            done_q       <= done_d;
        end
    end

    assign Serial_out = serial_q;
    assign TX_ready   = !hold_valid_q;
    assign TX_busy    = (state_q != ST_IDLE);
    assign TX_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a frame-level model predicts accepted bytes and
// frame start / done cycles; a negedge monitor decodes the line and compares.
module tb_uart_tx;

    localparam int BAUD  = 9600;
    localparam int FREQ  = 2000000;
    localparam int DIV   = FREQ / (BAUD * 16);
    localparam int BIT   = 16 * DIV;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       TX_start = 1'b0;
    logic [7:0] Data_in = 8'h00;
    logic       Serial_out, TX_ready, TX_busy, TX_done;

    uart_tx #(.baudrate(BAUD), .freq(FREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .TX_start   (TX_start),
        .Data_in    (Data_in),
        .Serial_out (Serial_out),
        .TX_ready   (TX_ready),
        .TX_busy    (TX_busy),
        .TX_done    (TX_done)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Frame-level reference: a pending byte and a countdown of the frame in flight.
    bit         m_busy = 1'b0;
    bit         m_hold = 1'b0;
    int         m_left = 0;
    logic [7:0] m_hold_data = 8'h00;
    int         m_last_load = 0;

    int         exp_start[$];
    logic [7:0] exp_byte[$];
    int         exp_done[$];

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            if (errs < 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit st, input logic [7:0] d);
        bit acc, fend, ld;
        acc  = st && !m_hold;
        fend = m_busy && (m_left == 1);
        ld   = m_hold && (!m_busy || fend);
        if (ld) begin
            m_busy = 1'b1;
            m_left = FRAME;
            m_hold = 1'b0;
            m_last_load = cyc;
            exp_start.push_back(cyc);
            exp_byte.push_back(m_hold_data);
            exp_done.push_back(cyc + FRAME);
        end else if (fend) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
        end
        if (acc) begin
            m_hold = 1'b1;
            m_hold_data = d;
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model.
    task automatic step(input bit st, input logic [7:0] d);
        TX_start = st;
        Data_in  = d;
        @(posedge clk);
        cyc++;
        if (reset) model_edge(st, d);
        #1;
        TX_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((m_busy || m_hold) && b < 3 * FRAME) begin
            step(1'b0, 8'h00);
            b++;
        end
        if (m_busy || m_hold) chk("drain_timeout", 1, 0);
        idle(5);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_serial"}, Serial_out, 1);
        chk({tag, "_ready"},  TX_ready,   1);
        chk({tag, "_busy"},   TX_busy,    0);
        chk({tag, "_done"},   TX_done,    0);
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        m_busy = 1'b0;
        m_hold = 1'b0;
        exp_start.delete();
        exp_byte.delete();
        exp_done.delete();
    endtask

    // Monitor: decode frames at bit centres, check timing against the model.
    bit         in_frame = 1'b0;
    int         fstart = 0;
    logic [7:0] rx = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 1'b0;
        end else begin
            chk("tx_ready", TX_ready, !m_hold);
            chk("tx_busy",  TX_busy,  m_busy);
            if (exp_done.size() > 0 && exp_done[0] == cyc) begin
                chk("tx_done_pulse", TX_done, 1);
                void'(exp_done.pop_front());
            end else if (TX_done) begin
                chk("tx_done_spurious", 1, 0);
            end
            if (!in_frame && Serial_out == 1'b0) begin
                in_frame = 1'b1;
                fstart = cyc;
                if (exp_start.size() == 0) chk("frame_unexpected", 1, 0);
                else chk("frame_start_cycle", cyc, exp_start.pop_front());
            end
            if (in_frame) begin
                int k, idx;
                k = cyc - fstart;
                if (k % BIT == BIT / 2) begin
                    idx = k / BIT;
                    if (idx == 0) chk("start_bit", Serial_out, 0);
                    else if (idx <= 8) rx[idx-1] = Serial_out;
                    else begin
                        chk("stop_bit", Serial_out, 1);
                        if (exp_byte.size() == 0) chk("byte_unexpected", rx, -1);
                        else chk("frame_byte", rx, exp_byte.pop_front());
                    end
                end
                if (k == FRAME - 1) in_frame = 1'b0;
            end
        end
    end

    initial begin
        // Power-on reset, checked between clock edges.
        #1 reset = 1'b0;
        #1 check_reset_outputs("por");
        idle(3);
        #1 reset = 1'b1;
        idle(3);

        // Single frame from idle.
        step(1'b1, 8'hA5);
        drain();

        // Back-to-back: second byte queued while the first is shifting.
        step(1'b1, 8'h00);
        idle(300);
        step(1'b1, 8'hFF);
        drain();

        // Writes on consecutive cycles: only those seeing an empty holding register land.
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        drain();

        // Overrun mid-frame: holding register full, third write is dropped.
        step(1'b1, 8'h44);
        idle(50);
        step(1'b1, 8'h55);
        idle(1);
        step(1'b1, 8'h66);
        drain();

        // Abort during data bit 3, then a clean frame.
        step(1'b1, 8'h5A);
        idle(1 + 4 * BIT + BIT / 2);
        #1 assert_reset();
        #1 check_reset_outputs("abort");
        idle(20);
        check_reset_outputs("abort_hold");
        #1 reset = 1'b1;
        idle(2);
        step(1'b1, 8'hC3);
        drain();

        // Accept on the exact edge the stop bit ends: one idle cycle, then the frame.
        step(1'b1, 8'h77);
        idle(1);
        while (cyc < m_last_load + FRAME - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h88);
        chk("boundary_line_idle", m_busy, 0);
        drain();

        // Random traffic at random spacing.
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(0, 2500));
            step(1'b1, 8'($urandom));
        end
        drain();

        chk("leftover_bytes",  exp_byte.size(),  0);
        chk("leftover_starts", exp_start.size(), 0);
        chk("leftover_dones",  exp_done.size(),  0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
